// File: rtl/alu_pkg.sv
// Shared opcode, state and one-hot helpers for the ALU issue/capture controller.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MULT = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The illegal opcode has no mux leg, so it maps to an all-zero select.
    function automatic logic [6:0] onehot7(input logic [2:0] op);
        logic [6:0] oh;
        oh = '0;
        if (op != OP_ILL) oh[op] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU mux and result signals of the issue controller, with master/slave views.
interface alu_issue_ctrl_if #(parameter int K = 7);

    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [K-1:0] in_a;
    logic [K-1:0] in_b;
    logic [K-1:0] opa;
    logic [K-1:0] opb;
    logic [6:0]   sel;
    logic [K-1:0] mux_out;
    logic         out_valid;
    logic         out_ready;
    logic [K-1:0] result;
    logic         err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, mux_out, out_ready,
        output in_ready, opa, opb, sel, out_valid, result, err
    );

    modport master (
        output in_valid, in_op, in_a, in_b, mux_out, out_ready,
        input  in_ready, opa, opb, sel, out_valid, result, err
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot mux select plus multiply/illegal flags.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] op,
    output logic [6:0] sel_oh,
    output logic       is_mult,
    output logic       is_illegal
);

    assign sel_oh     = onehot7(op);
    assign is_mult    = (op == OP_MULT);
    assign is_illegal = (op == OP_ILL);

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue/capture controller: IDLE -> EXEC -> DONE with a multiply hold counter.
// Define ALU_PIPE_EN to accept the next request on the result-handshake edge.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int K       = 7,
    parameter int MUL_LAT = 4
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave bus
);

    localparam int CW = $clog2(MUL_LAT) + 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [K-1:0]   opa_q,   opa_d;
    logic [K-1:0]   opb_q,   opb_d;
    logic [6:0]     sel_q,   sel_d;
    logic [K-1:0]   result_q, result_d;
    logic           err_q,   err_d;

    logic [6:0]     dec_sel;
    logic           dec_mult;
    logic           dec_illegal;
    logic           load;

    alu_op_decode u_decode (
        .op         (bus.in_op),
        .sel_oh     (dec_sel),
        .is_mult    (dec_mult),
        .is_illegal (dec_illegal)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sel_d    = sel_q;
        result_d = result_q;
        err_d    = err_q;
        load     = 1'b0;

        case (state_q)
            ST_IDLE: load = bus.in_valid;
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    result_d = bus.mux_out;
                    err_d    = 1'b0;
                    sel_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
`ifdef ALU_PIPE_EN
                    load    = bus.in_valid;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Illegal ops skip EXEC and report immediately with a zero result.
        if (load) begin
            opa_d = bus.in_a;
            opb_d = bus.in_b;
            if (dec_illegal) begin
                sel_d    = '0;
                result_d = '0;
                err_d    = 1'b1;
                state_d  = ST_DONE;
            end else begin
                sel_d   = dec_sel;
                cnt_d   = dec_mult ? CW'(MUL_LAT - 1) : '0;
                state_d = ST_EXEC;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; async reset clears every flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            sel_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

`ifdef ALU_PIPE_EN
    assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
`else
    assign bus.in_ready = (state_q == ST_IDLE);
`endif
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.sel       = sel_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU output mux (K=7, MUL_LAT=4).
module tb_alu_issue_ctrl;

    localparam int K       = 7;
    localparam int MUL_LAT = 4;

    typedef struct packed {
        logic [K-1:0] res;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.K(K)) bus ();

    alu_issue_ctrl #(.K(K), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Output mux model: an idle select returns a marker value that no test expects.
    always_comb begin
        bus.mux_out = 7'h5A;
        case (bus.sel)
            7'b0000001: bus.mux_out = bus.opa & bus.opb;
            7'b0000010: bus.mux_out = bus.opa | bus.opb;
            7'b0000100: bus.mux_out = bus.opa ^ bus.opb;
            7'b0001000: bus.mux_out = ~bus.opa;
            7'b0010000: bus.mux_out = bus.opa + bus.opb;
            7'b0100000: bus.mux_out = bus.opa - bus.opb;
            7'b1000000: bus.mux_out = bus.opa * bus.opb;
            default:    bus.mux_out = 7'h5A;
        endcase
    end

    function automatic exp_t model(input logic [2:0] op, input logic [K-1:0] a, input logic [K-1:0] b);
        exp_t e;
        e.err = 1'b0;
        case (op)
            3'd0:    e.res = a & b;
            3'd1:    e.res = a | b;
            3'd2:    e.res = a ^ b;
            3'd3:    e.res = ~a;
            3'd4:    e.res = a + b;
            3'd5:    e.res = a - b;
            3'd6:    e.res = a * b;
            default: begin e.res = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Result scoreboard: every completed handshake is matched against the oldest request.
    always @(posedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out_valid: result=%h err=%b with empty scoreboard", bus.result, bus.err);
            end else begin
                e = sb_q.pop_front();
                if ({bus.result, bus.err} !== e) begin
                    bad++;
                    $display("FAIL result: got result=%h err=%b, want result=%h err=%b", bus.result, bus.err, e.res, e.err);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.in_op    = 3'($urandom);
            bus.in_a     = K'($urandom);
            bus.in_b     = K'($urandom);
            @(posedge clk); #1;
            total++;
            if ({bus.in_ready, bus.out_valid, bus.sel, bus.result, bus.err, bus.opa, bus.opb} !==
                {1'b1, 1'b0, 7'b0, {K{1'b0}}, 1'b0, {K{1'b0}}, {K{1'b0}}}) begin
                bad++;
                $display("FAIL reset_state: in_ready=%b out_valid=%b sel=%b result=%h err=%b opa=%h opb=%h, want 1 0 0 0 0 0 0",
                         bus.in_ready, bus.out_valid, bus.sel, bus.result, bus.err, bus.opa, bus.opb);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [K-1:0] a, input logic [K-1:0] b,
                         input int exp_lat, input int exp_sel_cyc, input int hold, input string name);
        logic [6:0] exp_sel;
        exp_t       e;
        int         n, lat, sel_cyc;
        exp_sel = '0;
        if (op != 3'd7) exp_sel[op] = 1'b1;
        e = model(op, a, b);
        sb_q.push_back(e);
        @(negedge clk);
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL %s_accept: in_ready=%b after %0d cycles, want 1", name, bus.in_ready, n);
            bus.in_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        sel_cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.sel !== 7'b0) begin
                if (bus.sel === exp_sel) sel_cyc++;
                else begin
                    total++;
                    bad++;
                    $display("FAIL %s_sel_value: sel=%b at cycle %0d, want %b or 0", name, bus.sel, i, exp_sel);
                end
            end
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (lat != exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, exp_lat);
        end
        total++;
        if (sel_cyc != exp_sel_cyc) begin
            bad++;
            $display("FAIL %s_sel_cycles: sel=%b held %0d cycles, want %0d", name, exp_sel, sel_cyc, exp_sel_cyc);
        end
        if (hold > 0 && lat != 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                total++;
                if ({bus.out_valid, bus.in_ready, bus.result, bus.err} !== {1'b1, 1'b0, e.res, e.err}) begin
                    bad++;
                    $display("FAIL %s_hold: out_valid=%b in_ready=%b result=%h err=%b, want 1 0 %h %b",
                             name, bus.out_valid, bus.in_ready, bus.result, bus.err, e.res, e.err);
                end
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: out_valid=%b after handshake, want 0", name, bus.out_valid);
        end
    endtask

    task automatic test_add();
        do_op(3'd4, 7'h05, 7'h03, 2, 1, 0, "add");
    endtask

    task automatic test_mult();
        do_op(3'd6, 7'h03, 7'h05, MUL_LAT + 1, MUL_LAT, 0, "mult");
    endtask

    task automatic test_illegal();
        do_op(3'd7, 7'h2B, 7'h44, 1, 0, 0, "illegal");
    endtask

    task automatic test_logic_ops();
        for (int op = 0; op < 6; op++)
            do_op(3'(op), K'($urandom), K'($urandom), 2, 1, 0, "logic_ops");
        do_op(3'd6, 7'h7F, 7'h7F, MUL_LAT + 1, MUL_LAT, 0, "mult_wrap");
    endtask

    task automatic test_backpressure();
        do_op(3'd5, 7'h02, 7'h09, 2, 1, 3, "backpressure");
        do_op(3'd7, 7'h11, 7'h22, 1, 0, 3, "illegal_backpressure");
    endtask

    task automatic test_back_to_back();
        int  gap, exp_gap, n;
        logic rdy;
`ifdef ALU_PIPE_EN
        exp_gap = 2;
`else
        exp_gap = 3;
`endif
        sb_q.push_back(model(3'd0, 7'h6C, 7'h3A));
        sb_q.push_back(model(3'd1, 7'h11, 7'h42));
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd0;
        bus.in_a      = 7'h6C;
        bus.in_b      = 7'h3A;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_ready: in_ready=%b, want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_op = 3'd1;
        bus.in_a  = 7'h11;
        bus.in_b  = 7'h42;
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk); #1;
            gap++;
            if (rdy) break;
        end
        bus.in_valid = 1'b0;
        total++;
        if (gap != exp_gap) begin
            bad++;
            $display("FAIL b2b_gap: second accept %0d cycles after first, want %0d", gap, exp_gap);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: %0d results outstanding, want 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_mult();
        int stray;
        sb_q.push_back(model(3'd6, 7'h03, 7'h05));
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = 3'd6;
        bus.in_a      = 7'h03;
        bus.in_b      = 7'h05;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.sel !== 7'b1000000) begin
            bad++;
            $display("FAIL abort_in_exec: sel=%b before reset, want 1000000", bus.sel);
        end
        #1;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        total++;
        if ({bus.in_ready, bus.out_valid, bus.sel, bus.result, bus.err, bus.opa, bus.opb} !==
            {1'b1, 1'b0, 7'b0, {K{1'b0}}, 1'b0, {K{1'b0}}, {K{1'b0}}}) begin
            bad++;
            $display("FAIL abort_reset_state: in_ready=%b out_valid=%b sel=%b result=%h err=%b opa=%h opb=%h, want 1 0 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.sel, bus.result, bus.err, bus.opa, bus.opb);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_no_out_valid: out_valid seen on %0d cycles after release, want 0", stray);
        end
        do_op(3'd4, 7'h05, 7'h03, 2, 1, 0, "post_abort_add");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_add();
        test_mult();
        test_illegal();
        test_logic_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mult();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: %0d results never produced, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
